riscv_top: RTL and testbench



---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/riscv_if.sv | 12 +
 rtl/riscv_core.sv | 134 +++++++++++++
 rtl/riscv_top.sv | 47 ++++
 tb/tb_riscv_top.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared opcodes, control encodings and immediate extension for the single-cycle RV32I subset.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_ctrl_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmJ, ImmU} imm_src_e;

  typedef enum logic [1:0] {ResAlu, ResMem, ResPc4} result_src_e;

  function automatic logic [31:0] ext_imm(input logic [31:7] instr, input imm_src_e src);
    case (src)
      ImmS:    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ:    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      ImmU:    return {instr[31:12], 12'b0};
      default: return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

  // Sub only exists for R-type; addi must never pick it up from its immediate bits.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic is_sub);
    case (funct3)
      3'b000:  return is_sub ? AluSub : AluAdd;
      3'b111:  return AluAnd;
      3'b110:  return AluOr;
      3'b010:  return AluSlt;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/riscv_if.sv
// Core-to-memory bus: instruction fetch plus the data-memory read/write port.
interface riscv_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_write;

  modport master (output pc, data_adr, write_data, mem_write, input instr, read_data);
  modport slave  (input pc, data_adr, write_data, mem_write, output instr, read_data);
endinterface

// File: rtl/riscv_core.sv
// Single-cycle controller and datapath. Define RV_LUI_EN to decode lui; otherwise it is a no-op.
module riscv_core
  import riscv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  riscv_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7b5;

  assign opcode   = bus.instr[6:0];
  assign rd       = bus.instr[11:7];
  assign funct3   = bus.instr[14:12];
  assign rs1      = bus.instr[19:15];
  assign rs2      = bus.instr[24:20];
  assign funct7b5 = bus.instr[30];

  logic        reg_write, mem_write, alu_src, branch, jump, lui_sel;
  imm_src_e    imm_src;
  result_src_e result_src;
  alu_ctrl_e   alu_ctrl;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    lui_sel    = 1'b0;
    imm_src    = ImmI;
    result_src = ResAlu;
    alu_ctrl   = AluAdd;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = ResMem;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = ImmS;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_ctrl  = alu_decode(funct3, funct7b5);
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = alu_decode(funct3, 1'b0);
      end
      OP_BEQ: begin
        branch   = 1'b1;
        imm_src  = ImmB;
        alu_ctrl = AluSub;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        imm_src    = ImmJ;
        result_src = ResPc4;
      end
`ifdef RV_LUI_EN
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = ImmU;
        lui_sel   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  logic [31:0] imm_ext, rd1, rd2, src_a, src_b, alu_res, result, pc_plus4, pc_target;

  assign imm_ext = ext_imm(bus.instr[31:7], imm_src);
  assign rd1     = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rd2     = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  // lui passes the U-immediate straight through an add with zero.
  assign src_a   = lui_sel ? '0 : rd1;
  assign src_b   = alu_src ? imm_ext : rd2;

  always_comb begin
    case (alu_ctrl)
      AluSub:  alu_res = src_a - src_b;
      AluAnd:  alu_res = src_a & src_b;
      AluOr:   alu_res = src_a | src_b;
      AluSlt:  alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_res = src_a + src_b;
    endcase
  end

  always_comb begin
    case (result_src)
      ResMem:  result = bus.read_data;
      ResPc4:  result = pc_plus4;
      default: result = alu_res;
    endcase
  end

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm_ext;
  assign pc_d      = (jump || (branch && (alu_res == '0))) ? pc_target : pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // No reset on the register file; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (reg_write && !reset && (rd != 5'd0)) begin
      rf_q[rd] <= result;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.data_adr   = alu_res;
  assign bus.write_data = rd2;
  assign bus.mem_write  = mem_write;

endmodule

// File: rtl/riscv_top.sv
// Single-cycle RV32I-subset processor with instruction ROM and data RAM (lui gated by RV_LUI_EN).
module riscv_top
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter string       IMEM_FILE  = "riscvtest.txt"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  riscv_if bus ();

  logic [31:0]    imem [IMEM_WORDS];
  logic [31:0]    dmem [DMEM_WORDS];
  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;

  riscv_core u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign imem_idx      = IAW'((bus.pc >> 2) % IMEM_WORDS);
  assign dmem_idx      = DAW'((bus.data_adr >> 2) % DMEM_WORDS);
  assign bus.instr     = imem[imem_idx];
  assign bus.read_data = dmem[dmem_idx];

  always_ff @(posedge clk) begin
    if (bus.mem_write && !reset) begin
      dmem[dmem_idx] <= bus.write_data;
    end
  end

  assign WriteData = bus.write_data;
  assign DataAdr   = bus.data_adr;
  assign MemWrite  = bus.mem_write;

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: directed and random programs checked against an instruction-level model.
module tb_riscv_top;

  localparam int unsigned IMEM_WORDS = 64;
  localparam int unsigned DMEM_WORDS = 64;
  localparam logic [31:0] LOOP = 32'h0000_0063;  // beq x0,x0,0

  typedef struct {
    logic        we;
    logic        chk_adr;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b1;
  logic reset = 1'b1;
  riscv_if mon_if ();

  riscv_top #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .IMEM_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (mon_if.write_data),
    .DataAdr   (mon_if.data_adr),
    .MemWrite  (mon_if.mem_write)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  exp_t        exp_q [$];
  logic [31:0] img [$];
  logic [31:0] m_imem [IMEM_WORDS];
  logic [31:0] m_dmem [DMEM_WORDS];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  int unsigned store_cnt;
  logic [31:0] last_adr, last_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic sub, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {1'b0, sub, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [31:0] imm);
    return enc_i(7'b0010011, rd, 3'b000, rs1, imm);
  endfunction

  task automatic wr_reg(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) m_rf[rd] = v;
  endtask

  // Architectural step of the instruction at m_pc; records what the bus must show.
  task automatic model_step();
    logic [31:0] ins, a, b, adr, nxt, immi, imms, immb, immj;
    exp_t e;
    ins  = m_imem[(m_pc >> 2) % IMEM_WORDS];
    a    = m_rf[ins[19:15]];
    b    = m_rf[ins[24:20]];
    immi = 32'($signed(ins[31:20]));
    imms = 32'($signed({ins[31:25], ins[11:7]}));
    immb = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    immj = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e = '{we: 1'b0, chk_adr: 1'b0, adr: '0, wd: b, pc: m_pc};
    nxt = m_pc + 4;
    case (ins[6:0])
      7'b0000011: begin
        adr = a + immi;
        e.chk_adr = 1'b1; e.adr = adr;
        wr_reg(ins[11:7], m_dmem[(adr >> 2) % DMEM_WORDS]);
      end
      7'b0100011: begin
        adr = a + imms;
        e.we = 1'b1; e.chk_adr = 1'b1; e.adr = adr;
        m_dmem[(adr >> 2) % DMEM_WORDS] = b;
      end
      7'b0110011, 7'b0010011: begin
        logic [31:0] y, opb;
        opb = ins[5] ? b : immi;
        case (ins[14:12])
          3'b111:  y = a & opb;
          3'b110:  y = a | opb;
          3'b010:  y = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
          default: y = (ins[5] && ins[30]) ? a - opb : a + opb;
        endcase
        e.chk_adr = 1'b1; e.adr = y;
        wr_reg(ins[11:7], y);
      end
      7'b1100011: if (a == b) nxt = m_pc + immb;
      7'b1101111: begin
        wr_reg(ins[11:7], m_pc + 4);
        nxt = m_pc + immj;
      end
`ifdef RV_LUI_EN
      7'b0110111: begin
        e.chk_adr = 1'b1; e.adr = {ins[31:12], 12'b0};
        wr_reg(ins[11:7], {ins[31:12], 12'b0});
      end
`endif
      default: ;
    endcase
    exp_q.push_back(e);
    m_pc = nxt;
  endtask

  task automatic run_cycles(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      model_step();
      @(posedge clk);
    end
    #1 check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic start_image(input int cycles);
    logic [31:0] w;
    reset = 1'b1;
    for (int i = 0; i < int'(IMEM_WORDS); i++) begin
      w = (i < img.size()) ? img[i] : LOOP;
      m_imem[i] = w;
      dut.imem[i] = w;
    end
    store_cnt = 0; last_adr = '1; last_wd = '1;
    m_pc = '0;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b0;
    run_cycles(cycles);
  endtask

  // Monitor: one expected record per executed instruction, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("MemWrite pc=%0h", e.pc), {31'b0, mon_if.mem_write}, {31'b0, e.we});
        check($sformatf("WriteData pc=%0h", e.pc), mon_if.write_data, e.wd);
        if (e.chk_adr) check($sformatf("DataAdr pc=%0h", e.pc), mon_if.data_adr, e.adr);
        if (mon_if.mem_write) begin
          store_cnt++; last_adr = mon_if.data_adr; last_wd = mon_if.write_data;
        end
      end
    end
  end

  task automatic load_standard();
    img = {addi(2, 0, 5), addi(3, 0, 12), addi(7, 3, -9),
           enc_r(0, 4, 3'b110, 7, 2), enc_r(0, 5, 3'b111, 3, 4), enc_r(0, 5, 3'b000, 5, 4),
           enc_b(5, 7, 48), enc_r(0, 4, 3'b010, 3, 4), enc_b(4, 0, 8), addi(5, 0, 0),
           enc_r(0, 4, 3'b010, 7, 2), enc_r(0, 7, 3'b000, 4, 5), enc_r(1, 7, 3'b000, 7, 2),
           enc_s(7, 3, 84), enc_i(7'b0000011, 2, 3'b010, 0, 96), enc_r(0, 9, 3'b000, 2, 5),
           enc_j(3, 8), addi(2, 0, 1), enc_r(0, 2, 3'b000, 2, 9), enc_s(2, 3, 32), LOOP};
  endtask

  function automatic logic [2:0] pick_f3();
    case ($urandom_range(0, 3))
      0: return 3'b000;
      1: return 3'b111;
      2: return 3'b110;
      default: return 3'b010;
    endcase
  endfunction

  task automatic gen_random();
    logic [31:0] r, off;
    logic [4:0] rd, rs1, rs2;
    img = {};
    for (int k = 1; k < 8; k++) begin
      r = $urandom();
      img.push_back(addi(5'(k), 0, r));
    end
    for (int k = 0; k < 8; k++) img.push_back(enc_s(0, 0, 32'(4 * k)));
    for (int i = 0; i < 40; i++) begin
      r   = $urandom();
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 1) == 0) ? rs1 : 5'($urandom_range(0, 7));
      off = 32'(4 * $urandom_range(0, 7) + 256 * $urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 9: img.push_back(enc_r(r[0], rd, pick_f3(), rs1, rs2));
        1, 2: img.push_back(enc_i(7'b0010011, rd, pick_f3(), rs1, r));
        3:    img.push_back(enc_i(7'b0000011, rd, 3'b010, 0, off));
        4:    img.push_back(enc_s(rs2, 0, off));
        5:    img.push_back(enc_b(rs1, rs2, 32'(4 * $urandom_range(1, 4))));
        6:    img.push_back(enc_j(rd, 32'(4 * $urandom_range(1, 4))));
        7:    img.push_back({r[19:0], rd, 7'b0110111});
        default: img.push_back({r[31:7], 7'b0001111});
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < int'(DMEM_WORDS); i++) m_dmem[i] = '0;

    // Standard program: stores only to 96 then 100.
    load_standard();
    start_image(30);
    check("std store count", store_cnt, 2);
    check("std last DataAdr", last_adr, 32'd100);
    check("std last WriteData", last_wd, 32'd25);

    // lui x3,0x12345 ; sw x3,12(x0), with x3 cleared first.
    img = {addi(3, 0, 0), {20'h12345, 5'd3, 7'b0110111}, enc_s(3, 0, 12)};
    start_image(5);
    check("lui DataAdr", last_adr, 32'd12);
`ifdef RV_LUI_EN
    check("lui WriteData", last_wd, 32'h1234_5000);
`else
    check("lui WriteData", last_wd, 32'h0);
`endif

    // x0 is hardwired.
    img = {addi(0, 0, 5), enc_s(0, 0, 0)};
    start_image(4);
    check("x0 store count", store_cnt, 1);
    check("x0 DataAdr", last_adr, 32'd0);
    check("x0 WriteData", last_wd, 32'd0);

    // Taken beq skips the first store.
    img = {addi(1, 0, 3), addi(2, 0, 3), enc_b(1, 2, 8), enc_s(1, 0, 0), enc_s(2, 0, 4)};
    start_image(7);
    check("beq store count", store_cnt, 1);
    check("beq DataAdr", last_adr, 32'd4);
    check("beq WriteData", last_wd, 32'd3);

    // jal link value.
    img = {enc_j(1, 8), addi(0, 0, 0), enc_s(1, 0, 8)};
    start_image(4);
    check("jal DataAdr", last_adr, 32'd8);
    check("jal WriteData", last_wd, 32'd4);

    // Reset mid-run: PC back to 0 at once, then full restart.
    load_standard();
    start_image(5);
    #1 reset = 1'b1;
    #1 check("reset DataAdr", mon_if.data_adr, 32'd5);
    check("reset MemWrite", {31'b0, mon_if.mem_write}, 32'd0);
    store_cnt = 0; last_adr = '1; last_wd = '1;
    m_pc = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    run_cycles(30);
    check("restart store count", store_cnt, 2);
    check("restart last DataAdr", last_adr, 32'd100);
    check("restart last WriteData", last_wd, 32'd25);

    // Random programs against the model.
    for (int p = 0; p < 20; p++) begin
      gen_random();
      start_image(60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
